envelope_pwm_out: RTL
=====================

// Module: envelope_pwm_out
// PURPOSE
//   Output stage fed by the gate and the oscillator square wave. Shapes each note
//   with an attack/decay/sustain/release amplitude envelope. Renders the envelope
//   as a PWM density, ANDed with the oscillator, to drive the single-bit audio pin.
//   Replaces the bare "osc & gate" output with click-free, level-controlled notes.
// PARAMETERS
//   LEVEL_BITS   8   envelope level width; PWM counter width equals this
//   RATE_BITS    16  width of the attack/release rate inputs (prescaler width)
//   EXP_SHIFT    3   right-shift for the exponential release step (macro only)
// PORTS
//   clk            in   1           system clock
//   rst            in   1           synchronous, active-high reset
//   gate           in   1           note on/off level; edges detected internally
//   osc_in         in   1           oscillator square wave
//   attack_rate    in   RATE_BITS   clocks per attack step, minus 1
//   release_rate   in   RATE_BITS   clocks per decay/release step, minus 1
//   sustain_level  in   LEVEL_BITS  decay target and sustain hold level
//   level          out  LEVEL_BITS  current envelope level
//   state          out  3           0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//   busy           out  1           high when state != IDLE
//   pwmout         out  1           registered audio output
// BEHAVIOUR
//   - Reset: level=0, state=IDLE, busy=0, pwmout=0, prescaler=0, PWM counter=0.
//     The gate history register clears to 0, so a gate held high through reset
//     counts as a rise on the first cycle after reset.
//   - Edge detect: gate_q <= gate. rise = gate & ~gate_q. fall = ~gate & gate_q.
//     The state changes on the same edge that samples the rise/fall (latency 1 clk).
//   - Prescaler: cleared on every state entry. Counts up each clk.
//     - tick when prescaler == active rate, and the prescaler clears.
//     - One level step every rate+1 clks. Rate 0 gives a step every clk.
//     - ATTACK uses attack_rate. DECAY and RELEASE use release_rate.
//   - IDLE: level held at 0. On rise -> ATTACK.
//   - ATTACK: on tick, level+1.
//     - When a tick makes level = max (2^LEVEL_BITS-1) -> DECAY.
//   - DECAY:
//     - If level <= sustain_level, -> SUSTAIN next clk.
//     - Otherwise, on tick, level-1.
//   - SUSTAIN: level <= sustain_level every clk; live changes are tracked.
//   - Any gated state (ATTACK/DECAY/SUSTAIN) with fall -> RELEASE; level is kept.
//   - RELEASE: on tick, level-1. Level 0 -> IDLE; busy drops the same edge.
//   - Rise in RELEASE or DECAY -> ATTACK from the current level (no drop to 0).
//   - Rise and fall on the same cycle cannot occur; rise takes priority over tick.
//   - No wrap: level saturates at 0 and at max.
//   - PWM: free-running LEVEL_BITS counter pc, wraps at 2^LEVEL_BITS.
//     pwmout <= osc_in & (pc < level). Level 0 gives constant 0. Max gives
//     (2^N-1)/2^N duty.
//   - Mid-operation rst: all state returns to reset values on that edge. No partial step.
// CONFIGURATION
//   ENV_EXP_RELEASE_EN
//   - Defined: each RELEASE tick subtracts max(level >> EXP_SHIFT, 1), saturating at 0.
//     This gives an exponential-like tail that still reaches 0.
//   - Undefined: RELEASE subtracts 1 per tick (linear). EXP_SHIFT is unused.
//   - ATTACK and DECAY are linear in both builds.
// TESTING
//   1. rst=1 for 2 clks with gate=1 -> level=0, state=0, pwmout=0; first clk after rst
//      -> state=1.
//   2. attack_rate=3, release_rate=1, sustain=128, gate rise -> level +1 every 4 clks.
//      Reaches 255 at 1020 clks -> DECAY. Falls to 128 in 254 clks -> SUSTAIN.
//   3. In SUSTAIN at 128, release_rate=0, gate falls -> level 0 after 128 clks.
//      state=IDLE and busy=0 on that edge.
//   4. Gate falls, then rises again while level=40 in RELEASE -> state=ATTACK with
//      level=40, next attack tick gives 41.
//   5. sustain=64, osc_in=1 in SUSTAIN -> pwmout high for exactly 64 of every 256 clks.
//      osc_in=0 -> pwmout=0 throughout.
//   6. With ENV_EXP_RELEASE_EN, release_rate=0, from 255 -> level 224,196,172,...
//      then steps of 1 below 8, ending at 0 then IDLE. Without it -> 255,254,253,...

Source files
------------

// File: rtl/envelope_pwm_out_if.sv
// Signal bundle between the note/oscillator source and the envelope PWM output stage.
// master drives gate, oscillator and envelope settings; slave returns level, state and the audio pin.
interface envelope_pwm_out_if #(
  parameter int LEVEL_BITS = 8,
  parameter int RATE_BITS  = 16
);
  logic                  gate;
  logic                  osc_in;
  logic [RATE_BITS-1:0]  attack_rate;
  logic [RATE_BITS-1:0]  release_rate;
  logic [LEVEL_BITS-1:0] sustain_level;
  logic [LEVEL_BITS-1:0] level;
  logic [2:0]            state;
  logic                  busy;
  logic                  pwmout;

  modport master (
    output gate, osc_in, attack_rate, release_rate, sustain_level,
    input  level, state, busy, pwmout
  );

  modport slave (
    input  gate, osc_in, attack_rate, release_rate, sustain_level,
    output level, state, busy, pwmout
  );
endinterface

// File: rtl/envelope_pwm_out.sv
// ADSR envelope shaping the oscillator square wave, rendered as PWM density on one output pin.
// Define ENV_EXP_RELEASE_EN for an exponential-like release tail (step = max(level >> EXP_SHIFT, 1)).
module envelope_pwm_out #(
  parameter int LEVEL_BITS = 8,
  parameter int RATE_BITS  = 16,
  parameter int EXP_SHIFT  = 3
) (
  input  logic               clk,
  input  logic               rst,
  envelope_pwm_out_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [LEVEL_BITS-1:0] LEVEL_ONE = LEVEL_BITS'(1);

`ifdef ENV_EXP_RELEASE_EN
  localparam bit EXP_EN = 1'b1;
`else
  localparam bit EXP_EN = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [LEVEL_BITS-1:0] level_q, level_d;
  logic [RATE_BITS-1:0]  presc_q, presc_d;
  logic [LEVEL_BITS-1:0] pc_q, pc_d;
  logic                  gate_q, gate_d;
  logic                  pwmout_q, pwmout_d;

  logic                  rise;
  logic                  fall;
  logic                  tick;
  logic [RATE_BITS-1:0]  active_rate;
  logic [LEVEL_BITS-1:0] level_shifted;
  logic [LEVEL_BITS-1:0] rel_step;
  logic [LEVEL_BITS-1:0] level_inc;
  logic [LEVEL_BITS-1:0] level_rel;

  // Step arithmetic shared by the state machine; both directions saturate.
  always_comb begin
    rise          = bus.gate & ~gate_q;
    fall          = ~bus.gate & gate_q;
    active_rate   = (state_q == ST_ATTACK) ? bus.attack_rate : bus.release_rate;
    tick          = (presc_q == active_rate);
    level_shifted = level_q >> EXP_SHIFT;
    rel_step      = (EXP_EN && (level_shifted != '0)) ? level_shifted : LEVEL_ONE;
    level_inc     = (level_q == LEVEL_MAX) ? LEVEL_MAX : level_q + LEVEL_ONE;
    level_rel     = (level_q > rel_step) ? level_q - rel_step : '0;
  end

  // Next state and level; rise wins over fall, fall wins over a pending tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      ST_IDLE: begin
        level_d = '0;
        if (rise) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (fall) begin
          state_d = ST_RELEASE;
        end else if (tick) begin
          level_d = level_inc;
          if (level_inc == LEVEL_MAX) state_d = ST_DECAY;
        end
      end
      ST_DECAY: begin
        if (rise) begin
          state_d = ST_ATTACK;
        end else if (fall) begin
          state_d = ST_RELEASE;
        end else if (level_q <= bus.sustain_level) begin
          state_d = ST_SUSTAIN;
        end else if (tick) begin
          level_d = level_q - LEVEL_ONE;
        end
      end
      ST_SUSTAIN: begin
        if (fall) begin
          state_d = ST_RELEASE;
        end else begin
          level_d = bus.sustain_level;
        end
      end
      ST_RELEASE: begin
        if (rise) begin
          state_d = ST_ATTACK;
        end else if (tick) begin
          level_d = level_rel;
          if (level_rel == '0) state_d = ST_IDLE;
        end else if (level_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = '0;
      end
    endcase
  end

  // Prescaler restarts on every state entry so each phase gets full-length steps.
  always_comb begin
    gate_d   = bus.gate;
    pc_d     = pc_q + LEVEL_ONE;
    pwmout_d = bus.osc_in & (pc_q < level_q);
    if (state_d != state_q || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + RATE_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      presc_q  <= '0;
      pc_q     <= '0;
      gate_q   <= 1'b0;
      pwmout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      presc_q  <= presc_d;
      pc_q     <= pc_d;
      gate_q   <= gate_d;
      pwmout_q <= pwmout_d;
    end
  end

  assign bus.level  = level_q;
  assign bus.state  = state_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.pwmout = pwmout_q;

endmodule
